// File: rtl/rst_sequencer.sv
// rst_sequencer: stretches reset and releases NUM_CH channel resets in order.
// Optional watchdog is enabled by defining RST_SEQ_WDOG_EN.
module rst_sequencer #(
  parameter int NUM_CH   = 3,
  parameter int STRETCH  = 16,
  parameter int STAGGER  = 8,
  parameter int WDOG_CYC = 1048576
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              sw_rst_req_i,
  input  logic [NUM_CH-1:0] ch_hold_i,
  input  logic              wdog_kick_i,
  output logic [NUM_CH-1:0] rst_o,
  output logic              done_o,
  output logic              wdog_fired_o
);
  localparam int MX0 = (STRETCH > STAGGER) ? STRETCH : STAGGER;
  localparam int MX  = (MX0 > WDOG_CYC) ? MX0 : WDOG_CYC;
  localparam int W   = $clog2(MX + 1);
  localparam int CW  = $clog2(NUM_CH + 1);
  localparam logic [1:0] ASSERT = 2'd0, RELEASE = 2'd1, RUN = 2'd2;
  localparam logic [W-1:0] STR_M1 = W'(STRETCH - 1);
  localparam logic [W-1:0] STG_M1 = W'(STAGGER - 1);
  localparam logic [CW-1:0] LAST = CW'(NUM_CH - 1);
  logic [1:0]        st_q, st_d;
  logic [W-1:0]      cnt_q, cnt_d, cnt_inc;
  logic [CW-1:0]     ch_q, ch_d;
  logic [NUM_CH-1:0] rst_q, rst_d;
  logic              done_q, done_d;
  logic              fire;
  always_comb begin
    cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    st_d    = st_q;
    cnt_d   = cnt_inc;
    ch_d    = ch_q;
    rst_d   = rst_q;
    done_d  = done_q;
    fire    = 1'b0;
    if (st_q == ASSERT && cnt_q >= STR_M1 && !ch_hold_i[0]) begin
      rst_d[0] = 1'b0;
      ch_d     = CW'(1);
      cnt_d    = '0;
      st_d     = (NUM_CH == 1) ? RUN : RELEASE;
      done_d   = (NUM_CH == 1);
    end
    if (st_q == RELEASE && cnt_q >= STG_M1 && !ch_hold_i[ch_q]) begin
      rst_d[ch_q] = 1'b0;
      ch_d        = ch_q + 1'b1;
      cnt_d       = '0;
      st_d        = (ch_q == LAST) ? RUN : RELEASE;
      done_d      = (ch_q == LAST);
    end
    if (st_q == RUN) begin
`ifdef RST_SEQ_WDOG_EN
      cnt_d = wdog_kick_i ? '0 : cnt_inc;
      fire  = !wdog_kick_i && cnt_q >= W'(WDOG_CYC - 1);
`else
      cnt_d = cnt_q;
`endif
    end
    if (sw_rst_req_i || fire) begin
      st_d   = ASSERT;
      cnt_d  = '0;
      ch_d   = '0;
      rst_d  = '1;
      done_d = 1'b0;
    end
  end
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      st_q   <= ASSERT;
      cnt_q  <= '0;
      ch_q   <= '0;
      rst_q  <= '1;
      done_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      ch_q   <= ch_d;
      rst_q  <= rst_d;
      done_q <= done_d;
    end
  end
`ifdef RST_SEQ_WDOG_EN
  logic wdog_q;
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) wdog_q <= 1'b0;
    else if (fire) wdog_q <= 1'b1;
  end
  assign wdog_fired_o = wdog_q;
`else
  logic unused_kick;
  assign unused_kick  = wdog_kick_i;
  assign wdog_fired_o = 1'b0;
`endif
  assign rst_o  = rst_q;
  assign done_o = done_q;
endmodule
